// File: rtl/sync_fifo_pkg.sv
// -----------------------------------------------------------------------------
// sync_fifo_pkg
// Shared definitions for the synchronous FIFO slice:
//   DEF_DATA_W / DEF_DEPTH : default word width and entry count
//   fifo_op_e              : per-cycle operation class ({write accepted, read accepted})
//   cnt_width()            : width of the occupancy counter (must hold 0..DEPTH)
//   is_pow2()              : elaboration-time helper for the DEPTH legality check
// -----------------------------------------------------------------------------
package sync_fifo_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 16;

  // Encoding is {write accepted, read accepted} so it can be built by a cast.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_RD   = 2'b01,
    OP_WR   = 2'b10,
    OP_RW   = 2'b11
  } fifo_op_e;

  // One extra bit beyond the address width so that DEPTH itself is representable.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// -----------------------------------------------------------------------------
// sync_fifo_param_if
// Bus bundle between a FIFO user (master) and the FIFO (slave).
//   master drives : wr, rd, data_in
//   slave drives  : data_out, full, empty, almost_full, almost_empty,
//                   count, overflow, underflow
// Parameters must match those of the sync_fifo_param instance it connects to.
// -----------------------------------------------------------------------------
interface sync_fifo_param_if
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
);

  localparam int CNT_W = cnt_width(DEPTH);

  logic              wr;
  logic              rd;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              underflow;

  modport master (
    output wr, rd, data_in,
    input  data_out, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  wr, rd, data_in,
    output data_out, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

endinterface

// File: rtl/fifo_mem_dp.sv
// -----------------------------------------------------------------------------
// fifo_mem_dp
// Storage for the FIFO: DEPTH x DATA_W array with one write port and one
// registered read port.
//   clk   : clock
//   reset : async active-low, clears only the read register (not the array)
//   we    : write enable, stores wdata at waddr
//   re    : read enable, loads mem[raddr] into the read register
//   rdata : read register; holds its value while re=0
// A read and write to the same address in one cycle returns the old word.
// -----------------------------------------------------------------------------
module fifo_mem_dp #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 16,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem_q[raddr];
  end

  // Array deliberately has no reset so it maps onto RAM primitives.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sync_fifo_param.sv
// -----------------------------------------------------------------------------
// sync_fifo_param
// Single-clock FIFO with registered output, occupancy count and status flags.
//   clk   : clock, all state on rising edge
//   reset : asynchronous active-low reset; discards contents immediately
//   bus   : sync_fifo_param_if.slave
//     wr/data_in   write request and data
//     rd           read request; data_out valid one cycle later
//     full/empty/almost_full/almost_empty/count : registered status
//     overflow/underflow : one-cycle pulse on a rejected write/read
// Parameters: DATA_W (1..64), DEPTH (power of two, 4..1024),
//   AF_LEVEL (almost_full when count >= AF_LEVEL),
//   AE_LEVEL (almost_empty when count <= AE_LEVEL).
// -----------------------------------------------------------------------------
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input logic              clk,
  input logic              reset,
  sync_fifo_param_if.slave bus
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = cnt_width(DEPTH);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_LEVEL);

  // Parameter legality, rejected at elaboration.
  if (!is_pow2(DEPTH) || DEPTH < 4 || DEPTH > 1024) begin : g_bad_depth
    $error("sync_fifo_param: DEPTH=%0d must be a power of two in 4..1024", DEPTH);
  end
  if (DATA_W < 1 || DATA_W > 64) begin : g_bad_width
    $error("sync_fifo_param: DATA_W=%0d must be in 1..64", DATA_W);
  end
  if (AF_LEVEL > DEPTH) begin : g_bad_af
    $error("sync_fifo_param: AF_LEVEL=%0d exceeds DEPTH=%0d", AF_LEVEL, DEPTH);
  end
  if (AE_LEVEL >= AF_LEVEL || AE_LEVEL < 0) begin : g_bad_ae
    $error("sync_fifo_param: AE_LEVEL=%0d must be >= 0 and below AF_LEVEL=%0d",
           AE_LEVEL, AF_LEVEL);
  end

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              almost_full_q, almost_full_d;
  logic              almost_empty_q, almost_empty_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic              wr_ok;
  logic              rd_ok;
  fifo_op_e          op;
  logic [DATA_W-1:0] rdata;

  always_comb begin
    // A write into a full FIFO is still accepted when a read frees the slot
    // on the same edge; the read port returns the old word at that address.
    wr_ok = bus.wr && (!full_q || bus.rd);
    rd_ok = bus.rd && !empty_q;
    op    = fifo_op_e'({wr_ok, rd_ok});

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;  // power-of-two depth: natural wrap
    if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;

    count_d = count_q;
    unique case (op)
      OP_WR:   count_d = count_q + 1'b1;
      OP_RD:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Flags come from the next count so they line up with count_q.
    full_d         = (count_d == DEPTH_C);
    empty_d        = (count_d == '0);
    almost_full_d  = (count_d >= AF_C);
    almost_empty_d = (count_d <= AE_C);
    overflow_d     = bus.wr && !wr_ok;
    underflow_d    = bus.rd && !rd_ok;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      full_q         <= 1'b0;
      empty_q        <= 1'b1;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      full_q         <= full_d;
      empty_q        <= empty_d;
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
    end
  end

  fifo_mem_dp #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (wr_ok),
    .waddr (wr_ptr_q),
    .wdata (bus.data_in),
    .re    (rd_ok),
    .raddr (rd_ptr_q),
    .rdata (rdata)
  );

  assign bus.data_out     = rdata;
  assign bus.count        = count_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = almost_full_q;
  assign bus.almost_empty = almost_empty_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_param
// Two FIFO instances: dut_a (DATA_W=8, DEPTH=16) for directed vectors and
// corner sequences, dut_b (DATA_W=32, DEPTH=64) for random traffic against a
// reference queue.
// -----------------------------------------------------------------------------
module tb_sync_fifo_param;
  import sync_fifo_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_a = 1'b1;
  logic reset_b = 1'b1;

  sync_fifo_param_if #(.DATA_W(8),  .DEPTH(16)) bus_a ();
  sync_fifo_param_if #(.DATA_W(32), .DEPTH(64)) bus_b ();

  sync_fifo_param #(.DATA_W(8), .DEPTH(16)) dut_a (
    .clk   (clk),
    .reset (reset_a),
    .bus   (bus_a)
  );

  sync_fifo_param #(.DATA_W(32), .DEPTH(64)) dut_b (
    .clk   (clk),
    .reset (reset_b),
    .bus   (bus_b)
  );

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic       wr;
    logic       rd;
    logic [7:0] din;
    logic [4:0] cnt;
    logic       full;
    logic       empty;
    logic       af;
    logic       ae;
    logic       ovf;
    logic       unf;
    logic       chk_d;
    logic [7:0] dout;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input logic wr, input logic rd, input logic [7:0] din,
                              input logic [4:0] cnt, input logic full, input logic empty,
                              input logic af, input logic ae, input logic ovf,
                              input logic unf, input logic chk_d, input logic [7:0] dout);
    vec_t v;
    v.wr = wr; v.rd = rd; v.din = din; v.cnt = cnt; v.full = full; v.empty = empty;
    v.af = af; v.ae = ae; v.ovf = ovf; v.unf = unf; v.chk_d = chk_d; v.dout = dout;
    vecs.push_back(v);
  endfunction

  task automatic chk_reset_a(input string tag);
    chk({tag, " count"},    bus_a.count,        0);
    chk({tag, " empty"},    bus_a.empty,        1);
    chk({tag, " a_empty"},  bus_a.almost_empty, 1);
    chk({tag, " full"},     bus_a.full,         0);
    chk({tag, " a_full"},   bus_a.almost_full,  0);
    chk({tag, " overflow"}, bus_a.overflow,     0);
    chk({tag, " underflow"},bus_a.underflow,    0);
    chk({tag, " data_out"}, bus_a.data_out,     0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  sbq8[$];
    logic [7:0]  e8;
    logic [31:0] sbq32[$];
    logic [31:0] e32;
    logic [31:0] d32;
    logic        w, r, wok, rok;
    int          wth, rth;

    bus_a.wr = 1'b0; bus_a.rd = 1'b0; bus_a.data_in = '0;
    bus_b.wr = 1'b0; bus_b.rd = 1'b0; bus_b.data_in = '0;

    // ---------------- reset ----------------
    #1;
    reset_a = 1'b0;
    reset_b = 1'b0;
    tick();
    tick();
    chk_reset_a("reset");
    chk("reset b count", bus_b.count, 0);
    chk("reset b empty", bus_b.empty, 1);
    @(negedge clk);
    reset_a = 1'b1;
    reset_b = 1'b1;

    // ---------------- directed vector table (DEPTH=16, AF=14, AE=2) ----------------
    for (int i = 1; i <= 16; i++)
      add(1, 0, 8'(i), 5'(i), (i == 16), 0, (i >= 14), (i <= 2), 0, 0, 0, 8'h00);
    add(1, 0, 8'hAA, 5'd16, 1, 0, 1, 0, 1, 0, 0, 8'h00);          // overflow
    for (int i = 1; i <= 16; i++)
      add(0, 1, 8'h00, 5'(16 - i), 0, (i == 16), ((16 - i) >= 14), ((16 - i) <= 2),
          0, 0, 1, 8'(i));
    add(0, 1, 8'h00, 5'd0, 0, 1, 0, 1, 0, 1, 1, 8'h10);           // underflow, hold
    add(0, 0, 8'h00, 5'd0, 0, 1, 0, 1, 0, 0, 1, 8'h10);           // pulse clears
    add(1, 1, 8'h55, 5'd1, 0, 0, 0, 1, 0, 1, 1, 8'h10);           // empty wr+rd
    add(0, 1, 8'h00, 5'd0, 0, 1, 0, 1, 0, 0, 1, 8'h55);           // read back 0x55

    foreach (vecs[i]) begin
      bus_a.wr      = vecs[i].wr;
      bus_a.rd      = vecs[i].rd;
      bus_a.data_in = vecs[i].din;
      tick();
      chk($sformatf("v%0d count", i),     bus_a.count,        vecs[i].cnt);
      chk($sformatf("v%0d full", i),      bus_a.full,         vecs[i].full);
      chk($sformatf("v%0d empty", i),     bus_a.empty,        vecs[i].empty);
      chk($sformatf("v%0d a_full", i),    bus_a.almost_full,  vecs[i].af);
      chk($sformatf("v%0d a_empty", i),   bus_a.almost_empty, vecs[i].ae);
      chk($sformatf("v%0d overflow", i),  bus_a.overflow,     vecs[i].ovf);
      chk($sformatf("v%0d underflow", i), bus_a.underflow,    vecs[i].unf);
      if (vecs[i].chk_d)
        chk($sformatf("v%0d data_out", i), bus_a.data_out, vecs[i].dout);
    end
    bus_a.wr = 1'b0;
    bus_a.rd = 1'b0;

    // ---------------- full with simultaneous wr/rd across pointer wrap ----------------
    for (int i = 0; i < 16; i++) begin
      bus_a.wr = 1'b1;
      bus_a.data_in = 8'(8'h20 + i);
      sbq8.push_back(bus_a.data_in);
      tick();
    end
    bus_a.wr = 1'b0;
    chk("fill count", bus_a.count, 16);
    chk("fill full",  bus_a.full,  1);
    for (int k = 0; k < 40; k++) begin
      bus_a.wr = 1'b1;
      bus_a.rd = 1'b1;
      bus_a.data_in = 8'(8'h30 + k);
      e8 = sbq8.pop_front();
      sbq8.push_back(bus_a.data_in);
      tick();
      chk($sformatf("rw%0d count", k),    bus_a.count,    16);
      chk($sformatf("rw%0d overflow", k), bus_a.overflow, 0);
      chk($sformatf("rw%0d data", k),     bus_a.data_out, e8);
    end
    bus_a.wr = 1'b0;

    // ---------------- drain to 7, then asynchronous reset ----------------
    for (int k = 0; k < 9; k++) begin
      bus_a.rd = 1'b1;
      e8 = sbq8.pop_front();
      tick();
      chk($sformatf("drain%0d data", k), bus_a.data_out, e8);
    end
    bus_a.rd = 1'b0;
    chk("drain count", bus_a.count, 7);
    #2;
    reset_a = 1'b0;
    #1;
    chk_reset_a("async reset");
    @(negedge clk);
    reset_a = 1'b1;
    sbq8.delete();
    bus_a.wr = 1'b1;
    bus_a.data_in = 8'h77;
    tick();
    bus_a.wr = 1'b0;
    chk("post reset count", bus_a.count, 1);
    chk("post reset empty", bus_a.empty, 0);
    bus_a.rd = 1'b1;
    tick();
    bus_a.rd = 1'b0;
    chk("post reset data",  bus_a.data_out, 8'h77);
    chk("post reset count0", bus_a.count, 0);

    // ---------------- random traffic on DEPTH=64 against reference queue ----------------
    for (int cyc = 0; cyc < 10000; cyc++) begin
      case ((cyc / 500) % 3)
        0:       begin wth = 3; rth = 1; end   // fill-biased
        1:       begin wth = 1; rth = 3; end   // drain-biased
        default: begin wth = 2; rth = 2; end
      endcase
      w   = ($urandom_range(0, 3) < wth);
      r   = ($urandom_range(0, 3) < rth);
      d32 = $urandom;
      wok = w && ((sbq32.size() < 64) || r);
      rok = r && (sbq32.size() > 0);
      bus_b.wr = w;
      bus_b.rd = r;
      bus_b.data_in = d32;
      e32 = '0;
      if (rok) e32 = sbq32.pop_front();
      if (wok) sbq32.push_back(d32);
      tick();
      if (rok) chk($sformatf("rnd%0d data", cyc), bus_b.data_out, e32);
      chk($sformatf("rnd%0d count", cyc),     bus_b.count,     sbq32.size());
      chk($sformatf("rnd%0d full", cyc),      bus_b.full,      (sbq32.size() == 64));
      chk($sformatf("rnd%0d empty", cyc),     bus_b.empty,     (sbq32.size() == 0));
      chk($sformatf("rnd%0d overflow", cyc),  bus_b.overflow,  (w && !wok));
      chk($sformatf("rnd%0d underflow", cyc), bus_b.underflow, (r && !rok));
    end
    bus_b.wr = 1'b0;
    bus_b.rd = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

Interface
REQ-001 Parameter DATA_W, default 8, data word width in bits (1..64).
REQ-002 Parameter DEPTH, default 16, number of entries; SHALL be a power of two, 4..1024.
REQ-003 Parameter AF_LEVEL, default DEPTH-2, count at or above which almost_full asserts.
REQ-004 Parameter AE_LEVEL, default 2, count at or below which almost_empty asserts.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset; 0 = reset asserted.
REQ-007 wr  input  1  write request; data_in is sampled with it.
REQ-008 rd  input  1  read request.
REQ-009 data_in  input  DATA_W  write data.
REQ-010 data_out  output  DATA_W  registered read data.
REQ-011 full  output  1  count == DEPTH.
REQ-012 empty  output  1  count == 0.
REQ-013 almost_full  output  1  count >= AF_LEVEL.
REQ-014 almost_empty  output  1  count <= AE_LEVEL.
REQ-015 count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-016 overflow  output  1  one-cycle pulse on a rejected write.
REQ-017 underflow  output  1  one-cycle pulse on a rejected read.

Function
REQ-018 Write accepted when wr=1 and (full=0 or rd=1); the word is stored at wr_ptr, and wr_ptr increments modulo DEPTH.
REQ-019 Read accepted when rd=1 and empty=0; data_out loads mem[rd_ptr] on that edge (valid 1 cycle after rd), and rd_ptr increments modulo DEPTH.
REQ-020 data_out SHALL hold its last value when no read is accepted.
REQ-021 count: +1 on write-only, -1 on read-only, unchanged on simultaneous accepted read and write or on no accepted operation.
REQ-022 All flags SHALL be registered and derived from next-state count, so they are valid in the same cycle as count.
REQ-023 Full with wr=1, rd=1: both accepted, count stays DEPTH, overflow=0.
REQ-024 Empty with wr=1, rd=1: write accepted, read rejected, count becomes 1, underflow=1 for one cycle.
REQ-025 Full with wr=1, rd=0: write dropped, memory and pointers unchanged, overflow=1 for one cycle.
REQ-026 Empty with rd=1, wr=0: data_out unchanged, underflow=1 for one cycle.
REQ-027 Pointers SHALL wrap from DEPTH-1 to 0 without bubbles; no fall-through: a write is never visible on data_out in its own cycle.
REQ-028 Elaboration SHALL fail if DEPTH is not a power of two, if AE_LEVEL >= AF_LEVEL, or if AF_LEVEL > DEPTH.

Reset
REQ-029 While reset=0: pointers=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0, data_out=0.
REQ-030 Reset asserted mid-operation SHALL discard all contents immediately; memory array is not cleared.
REQ-031 The first accepted operation is on the first rising clk edge after reset deasserts.

Structure
REQ-032 Package sync_fifo_pkg SHALL hold default DATA_W/DEPTH constants and a function computing the count width.
REQ-033 Storage SHALL be a sub-module fifo_mem_dp: 1 write port and 1 registered read port, no reset on the array.
REQ-034 Pointer, count and flag logic SHALL reside in sync_fifo_param.

Verification
REQ-035 Reset, then write 0x01..0x10 (DEPTH=16) -> full=1 after the 16th write, almost_full=1 at count 14, count=16.
REQ-036 From full, write 0xAA with rd=0 -> overflow pulse, count=16; then 16 reads return 0x01..0x10 in order, with empty=1 after the last.
REQ-037 Empty, rd=1 -> underflow pulse, data_out unchanged; empty with wr=1, rd=1 and data 0x55 -> count=1, underflow pulse, then a read returns 0x55.
REQ-038 Full with wr=1, rd=1 for 40 cycles of an incrementing pattern -> count stays 16, no overflow, in-order data across pointer wrap.
REQ-039 reset=0 asserted asynchronously at count=7 -> outputs take reset values before the next edge, and subsequent data starts fresh.
REQ-040 Random wr/rd for 10k cycles with DATA_W=32, DEPTH=64 against a scoreboard queue -> zero mismatches, and count equals the model's occupancy every cycle.
